// File: rtl/fq_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fq_period_meter
//  Description : Measures the rise-to-rise period and rise-to-fall high time
//                of a slow clock-like input, counted in system clock cycles.
//                The measured signal is synchronized and treated as data.
//                Supports single-shot and continuous back-to-back operation,
//                with a cycle-count timeout when an expected edge never comes.
//  Revision    : 1.0 - initial release
// ============================================================================
module fq_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Synchronizer chain and edge-history flop
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;

    // FSM and datapath registers
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_high_tmp;
    logic             r_high_seen;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_busy;
    logic             r_timeout;

    // Next-state values
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_high_tmp_nxt;
    logic             w_high_seen_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic [CNT_W-1:0] w_high_nxt;
    logic             w_valid_nxt;
    logic             w_timeout_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_limit;

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_sync & ~r_hist;
    assign w_fall    = ~w_sync & r_hist;
    assign w_cnt_inc = r_cnt + C_ONE;
    // >= rather than == so a fall that suppresses the limit cycle still times
    // out one cycle later instead of letting the counter run on.
    assign w_limit   = (r_cnt >= C_LIMIT);

    // Bring the asynchronous input into the clk domain and keep one history bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], clk_in};
            r_hist <= w_sync;
        end
    end

    // Measurement FSM next-state and datapath decode
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_high_tmp_nxt  = r_high_tmp;
        w_high_seen_nxt = r_high_seen;
        w_period_nxt    = r_period;
        w_high_nxt      = r_high;
        w_valid_nxt     = 1'b0;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ARM;
                    w_cnt_nxt   = '0;
                end
            end
            S_ARM: begin
                if (w_rise) begin
                    w_state_nxt     = S_MEAS;
                    w_cnt_nxt       = '0;
                    w_high_seen_nxt = 1'b0;
                end else if (w_limit) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_MEAS: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_fall && !r_high_seen) begin
                    w_high_tmp_nxt  = w_cnt_inc;
                    w_high_seen_nxt = 1'b1;
                end
                if (w_rise) begin
                    // A rise without an earlier fall reports a 100% high time
                    w_state_nxt  = S_DONE;
                    w_period_nxt = w_cnt_inc;
                    w_high_nxt   = r_high_seen ? r_high_tmp : w_cnt_inc;
                    w_cnt_nxt    = '0;
                    w_valid_nxt  = 1'b1;
                end else if (w_limit && !w_fall) begin
                    w_state_nxt   = S_IDLE;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_DONE: begin
                if (cont) begin
                    // The terminating rise already began the next period
                    w_state_nxt     = S_MEAS;
                    w_cnt_nxt       = C_ONE;
                    w_high_seen_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state, counter, results and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_high_tmp  <= '0;
            r_high_seen <= 1'b0;
            r_period    <= '0;
            r_high      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_high_tmp  <= w_high_tmp_nxt;
            r_high_seen <= w_high_seen_nxt;
            r_period    <= w_period_nxt;
            r_high      <= w_high_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign period    = r_period;
    assign high_time = r_high;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fq_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fq_period_meter
//  Description : Directed self-checking bench for fq_period_meter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fq_period_meter;

    localparam int W  = 16;
    localparam int TO = 20;

    logic         clk    = 1'b0;
    logic         reset  = 1'b0;
    logic         clk_in;
    logic         start  = 1'b0;
    logic         cont   = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         busy;
    logic         timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int val_cnt  = 0;
    int tmo_cnt  = 0;
    int both_cnt = 0;

    bit gen_en  = 1'b0;
    int gen_hi  = 2;
    int gen_lo  = 2;
    int gen_cnt = 0;

    fq_period_meter #(
        .CNT_W      (W),
        .SYNC_STAGES(2),
        .TIMEOUT    (TO)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .clk_in   (clk_in),
        .start    (start),
        .cont     (cont),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Divided-clock source: gen_hi cycles high then gen_lo cycles low
    always @(negedge clk) begin
        if (gen_en) begin
            clk_in  = (gen_cnt < gen_hi);
            gen_cnt = (gen_cnt + 1 >= gen_hi + gen_lo) ? 0 : gen_cnt + 1;
        end else begin
            clk_in  = 1'b0;
            gen_cnt = 0;
        end
    end

    // Pulse monitor
    always @(negedge clk) begin
        if (valid === 1'b1) val_cnt++;
        if (timeout === 1'b1) tmo_cnt++;
        if (valid === 1'b1 && timeout === 1'b1) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Returns the number of ticks until valid is seen, or -1 if it never is
    task automatic wait_valid(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int v0;
        int t0;
        int tk;

        // Reset state
        repeat (3) tick();
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1'b1;
        tick();

        // Divide-by-4, single shot
        gen_hi = 2; gen_lo = 2; gen_en = 1'b1; cont = 1'b0;
        repeat (8) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(40, n);
        chk("t1_valid_seen", n > 0, 1);
        chk("t1_period", period, 4);
        chk("t1_high", high_time, 2);
        chk("t1_busy_done", busy, 1);
        tick();
        chk("t1_valid_low", valid, 0);
        chk("t1_busy_idle", busy, 0);

        // Divide-by-6, continuous
        gen_en = 1'b0; tick();
        gen_hi = 3; gen_lo = 3; gen_en = 1'b1;
        repeat (10) tick();
        cont = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(40, n);
        chk("t2_first_seen", n > 0, 1);
        chk("t2_period0", period, 6);
        chk("t2_high0", high_time, 3);
        for (int k = 0; k < 2; k++) begin
            wait_valid(20, n);
            chk("t2_interval", n, 6);
            chk("t2_period", period, 6);
            chk("t2_high", high_time, 3);
        end
        tick();
        cont = 1'b0;
        wait_valid(20, n);
        chk("t2_last_interval", n, 5);
        chk("t2_last_period", period, 6);
        tick();
        chk("t2_busy_after", busy, 0);
        v0 = val_cnt;
        repeat (20) tick();
        chk("t2_no_more_valid", val_cnt - v0, 0);

        // Timeout with clk_in held low
        gen_en = 1'b0;
        repeat (5) tick();
        t0 = tmo_cnt;
        start = 1'b1; tick(); start = 1'b0;
        tk = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (timeout === 1'b1 && tk == 0) tk = i;
        end
        chk("t3_timeout_cycle", tk, 20);
        chk("t3_period_kept", period, 6);
        chk("t3_high_kept", high_time, 3);
        chk("t3_busy_after", busy, 0);
        chk("t3_one_timeout", tmo_cnt - t0, 1);

        // Asynchronous reset in the middle of MEAS
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        gen_hi = 2; gen_lo = 2; gen_en = 1'b1;
        repeat (4) tick();
        chk("t4_busy_meas", busy, 1);
        v0 = val_cnt;
        t0 = tmo_cnt;
        reset = 1'b0;
        #1;
        chk("t4_rst_period", period, 0);
        chk("t4_rst_high", high_time, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_valid", valid, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("t4_no_pulses", (val_cnt - v0) + (tmo_cnt - t0), 0);
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(40, n);
        chk("t4_valid_seen", n > 0, 1);
        chk("t4_period", period, 4);
        chk("t4_high", high_time, 2);

        // start while busy is ignored
        tick();
        v0 = val_cnt;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("t5_busy", busy, 1);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (40) tick();
        chk("t5_one_valid", val_cnt - v0, 1);
        chk("t5_busy_end", busy, 0);

        // Asymmetric 1 high / 3 low
        gen_en = 1'b0; tick();
        gen_hi = 1; gen_lo = 3; gen_en = 1'b1;
        repeat (6) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_valid(40, n);
        chk("t6_valid_seen", n > 0, 1);
        chk("t6_period", period, 4);
        chk("t6_high", high_time, 1);

        // Rise coincides with counter == TIMEOUT-1: period 20 must still report
        tick();
        gen_en = 1'b0;
        repeat (5) tick();
        gen_hi = 1; gen_lo = 19;
        t0 = tmo_cnt;
        start = 1'b1; tick(); start = 1'b0;
        gen_en = 1'b1;
        wait_valid(80, n);
        chk("t7_valid_seen", n > 0, 1);
        chk("t7_period", period, 20);
        chk("t7_high", high_time, 1);
        chk("t7_no_timeout", tmo_cnt - t0, 0);

        chk("never_valid_and_timeout", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
